// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline payload types and NOP bundles.
// Also holds the saturating add used by the flush counter.
package pipe_stage_reg_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
   } alu_op_e;

   typedef enum logic [1:0] {
      MEM_BYTE, MEM_HALF, MEM_WORD
   } mem_op_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_reg_t;

   typedef struct packed {
      logic [31:0] pc;
      alu_op_e     alu_op;
      mem_op_e     mem_op;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
      logic [4:0]  rd;
   } id_ex_reg_t;

   localparam if_id_reg_t IF_ID_NOP = '{
      pc: RESET_PC, instr: INSTR_NOP
   };

   localparam id_ex_reg_t ID_EX_NOP = '{
      pc: RESET_PC, alu_op: ALU_ADD,
      mem_op: MEM_WORD, reg_we: 1'b0,
      mem_re: 1'b0, mem_we: 1'b0, rd: 5'd0
   };

   function automatic logic [31:0] sat_add(
      input logic [31:0] a,
      input logic [1:0]  b,
      input logic [31:0] max
   );
      logic [32:0] s;
      s = {1'b0, a} + {31'b0, b};
      return (s > {1'b0, max}) ? max : s[31:0];
   endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline slot: valid bit plus payload.
// Clear returns it to the NOP bundle; otherwise load or hold.
module pipe_slot
   import pipe_stage_reg_pkg::*;
#(
   parameter int              WIDTH     = 32,
   parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] ld_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // Reset/clear win over load; an empty slot always carries NOP.
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         valid <= 1'b0;
         data  <= NOP_VALUE;
      end else if (load) begin
         valid <= 1'b1;
         data  <= ld_data;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic handshaked pipeline stage register.
// Optional skid slot decouples in_ready from out_ready.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter bit               SKID_EN   = 1'b1,
   parameter logic [WIDTH-1:0] NOP_VALUE = '0,
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             stall,
   input  logic             flush,
   output logic [CNT_W-1:0] flush_drops
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             main_v;
   logic [WIDTH-1:0] main_d;
   logic             main_load;
   logic             main_clear;
   logic [WIDTH-1:0] main_nxt;
   logic             skid_v;
   logic             in_fire;
   logic             out_fire;
   logic [1:0]       drop_inc;

   assign out_fire = main_v & out_ready & ~stall;
   assign in_fire  = in_valid & in_ready;

   pipe_slot #(
      .WIDTH     (WIDTH),
      .NOP_VALUE (NOP_VALUE)
   ) u_main (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (main_load),
      .clear   (main_clear),
      .ld_data (main_nxt),
      .valid   (main_v),
      .data    (main_d)
   );

   generate
      if (SKID_EN) begin : g_skid
         logic             main_free;
         logic             skid_load;
         logic             skid_clear;
         logic [WIDTH-1:0] skid_d;

         assign main_free  = ~main_v | out_fire;
         assign in_ready   = ~skid_v & ~stall
                           & ~flush & reset_n;
         assign main_load  = ~flush & ~stall & main_free
                           & (skid_v | in_fire);
         assign main_nxt   = skid_v ? skid_d : in_data;
         assign main_clear = flush | (~stall & main_free
                           & ~skid_v & ~in_fire);
         assign skid_load  = in_fire & ~main_free;
         assign skid_clear = flush
                           | (~stall & main_free & skid_v);

         pipe_slot #(
            .WIDTH     (WIDTH),
            .NOP_VALUE (NOP_VALUE)
         ) u_skid (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (skid_load),
            .clear   (skid_clear),
            .ld_data (in_data),
            .valid   (skid_v),
            .data    (skid_d)
         );
      end else begin : g_noskid
         assign in_ready   = (~main_v | out_ready) & ~stall
                           & ~flush & reset_n;
         assign main_load  = in_fire;
         assign main_nxt   = in_data;
         assign main_clear = flush | (out_fire & ~in_fire);
         assign skid_v     = 1'b0;
      end
   endgenerate

   assign out_valid = main_v;
   assign out_data  = main_d;

   // A main entry leaving downstream this cycle is not a drop.
   assign drop_inc = {1'b0, main_v & ~out_fire}
                   + {1'b0, skid_v};

   // Saturating count of payloads killed by flush.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flush_drops <= '0;
      end else if (flush) begin
         flush_drops <= CNT_W'(sat_add(32'(flush_drops),
                        drop_inc, 32'(CNT_MAX)));
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid (CNT_W=2) and no-skid copies.
// Both are compared each cycle against a queue model.
module tb_pipe_stage_reg;

   localparam logic [31:0] NOP = 32'h13;

   logic        clk = 1'b0;
   logic        reset_n, in_valid, out_ready, stall, flush;
   logic [31:0] in_data;

   logic        rdy_a, ov_a;
   logic [31:0] od_a;
   logic [1:0]  fd_a;
   logic        rdy_b, ov_b;
   logic [31:0] od_b;
   logic [7:0]  fd_b;

   int tests = 0;
   int fails = 0;

   logic [31:0] q[2][$];
   int          drops[2];
   int          dmax[2] = '{3, 255};
   bit          m_rdy[2];
   bit          m_fin[2];
   bit          m_fout[2];

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .WIDTH(32), .SKID_EN(1'b1),
      .NOP_VALUE(NOP), .CNT_W(2)
   ) u_a (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(rdy_a),
      .in_data(in_data), .out_valid(ov_a),
      .out_ready(out_ready), .out_data(od_a),
      .stall(stall), .flush(flush),
      .flush_drops(fd_a)
   );

   pipe_stage_reg #(
      .WIDTH(32), .SKID_EN(1'b0),
      .NOP_VALUE(NOP), .CNT_W(8)
   ) u_b (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(rdy_b),
      .in_data(in_data), .out_valid(ov_b),
      .out_ready(out_ready), .out_data(od_b),
      .stall(stall), .flush(flush),
      .flush_drops(fd_b)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] head(input int k);
      return (q[k].size() > 0) ? q[k][0] : NOP;
   endfunction

   task automatic step(input bit do_chk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (!reset_n || stall || flush)
            m_rdy[k] = 1'b0;
         else if (k == 0)
            m_rdy[k] = q[k].size() < 2;
         else
            m_rdy[k] = (q[k].size() == 0) || out_ready;
         m_fin[k]  = in_valid && m_rdy[k];
         m_fout[k] = (q[k].size() > 0) && out_ready
                     && !stall;
      end
      if (do_chk) begin
         check("a_in_ready", 32'(rdy_a), 32'(m_rdy[0]));
         check("a_out_valid", 32'(ov_a),
               32'(q[0].size() > 0));
         check("a_out_data", od_a, head(0));
         check("a_flush_drops", 32'(fd_a), drops[0]);
         check("b_in_ready", 32'(rdy_b), 32'(m_rdy[1]));
         check("b_out_valid", 32'(ov_b),
               32'(q[1].size() > 0));
         check("b_out_data", od_b, head(1));
         check("b_flush_drops", 32'(fd_b), drops[1]);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!reset_n) begin
            q[k].delete();
            drops[k] = 0;
         end else if (flush) begin
            drops[k] += q[k].size() - int'(m_fout[k]);
            if (drops[k] > dmax[k]) drops[k] = dmax[k];
            q[k].delete();
         end else if (!stall) begin
            if (m_fout[k]) void'(q[k].pop_front());
            if (m_fin[k]) q[k].push_back(in_data);
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit rn, input bit iv,
                        input logic [31:0] d,
                        input bit ordy, input bit st,
                        input bit fl);
      reset_n   = rn;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      stall     = st;
      flush     = fl;
      step(1'b1);
   endtask

   initial begin
      reset_n = 0; in_valid = 0; in_data = 0;
      out_ready = 0; stall = 0; flush = 0;
      drops[0] = 0; drops[1] = 0;
      step(1'b0);
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 0);
      for (int i = 1; i <= 8; i++)
         drive(1, 1, 32'(i), 1, 0, 0);
      repeat (2) drive(1, 0, 0, 1, 0, 0);
      drive(1, 1, 32'hA, 0, 0, 0);
      drive(1, 1, 32'hB, 0, 0, 0);
      repeat (2) drive(1, 1, 32'hC, 0, 0, 0);
      repeat (2) drive(1, 1, 32'hC, 1, 0, 0);
      repeat (3) drive(1, 0, 0, 1, 0, 0);
      drive(1, 1, 32'h5, 0, 0, 0);
      repeat (3) drive(1, 0, 0, 1, 1, 0);
      repeat (2) drive(1, 0, 0, 1, 0, 0);
      for (int r = 0; r < 3; r++) begin
         drive(1, 1, 32'h7, 0, 0, 0);
         drive(1, 1, 32'h9, 0, 0, 0);
         drive(1, 0, 0, 0, 0, 1);
         drive(1, 0, 0, 0, 0, 0);
      end
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 1, 32'h21, 0, 0, 0);
      drive(1, 1, 32'h22, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 1);
      drive(1, 1, 32'h31, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 1);
      drive(1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 600; i++)
         drive($urandom_range(0, 79) != 0,
               $urandom_range(0, 3) != 0,
               $urandom,
               $urandom_range(0, 2) != 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 11) == 0);
      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
   end

endmodule
